agc_gain_apply: RTL
===================

Name: agc_gain_apply

Overview:
Digital variable-gain stage that applies the AGC's 8-bit gain code to the I/Q sample stream. It is the consumer end of the AGC gain interface and sits in the main-clock datapath after the AGC loop.
Gain changes are ramped one code step at a time to avoid output discontinuities. The datapath is a 3-stage multiply/shift/round/saturate pipeline.

Parameters:
INIT_GAIN, 8'h80, reset gain code for current and target gain (8'h80 = unity).
EXP_BIAS, 8, exponent bias of the gain code.
RAMP_DIV, 8, clk cycles per one-code ramp step; minimum 1.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
sample_valid  in  1  qualifies sample_i/sample_q
sample_i  in  12  signed I sample
sample_q  in  12  signed Q sample
gain_load  in  1  one-cycle strobe; captures gain_code as the new target
gain_code  in  8  [7:4] exponent e, [3:0] mantissa m
out_valid  out  1  qualifies out_i/out_q
out_i  out  12  signed scaled I
out_q  out  12  signed scaled Q
sat  out  1  either channel clipped on this output beat
gain_cur  out  8  gain code currently applied
ramping  out  1  high while gain_cur != target
sat_cnt  out  16  saturation event count (see Optional Feature)

Behaviour:
- Reset (rst=0, async): out_valid=0, out_i=0, out_q=0, sat=0, gain_cur=target=INIT_GAIN, ramping=0, ramp counter=0, sat_cnt=0, all pipeline valids cleared.
- Gain law: gain = (16+m)/16 * 2^(e-EXP_BIAS).
  - The code is monotonic as an unsigned integer.
  - Ramping steps that integer by ±1.
- Datapath per channel:
  - S1: register the sample and gain_cur.
  - S2: prod = sample * (16+m), 17-bit signed.
  - S3: w = (prod <<< e) + 2^(EXP_BIAS+3), computed in a 34-bit signed intermediate; r = w >>> (EXP_BIAS+4). Rounding is to nearest, ties toward +inf. Clip r to [-2048, 2047].
  - sat = OR of the clip events on I and Q.
- Latency: exactly 3 clk from sample_valid to out_valid. The gain used is gain_cur at S1 capture, so a ramp step never splits an I/Q pair. No backpressure; one sample per cycle is accepted.
- Ramp FSM:
  - IDLE: ramping=0, counter held at 0. On gain_load with gain_code != gain_cur, set target and go to RAMP.
  - RAMP: counter increments each clk. When counter == RAMP_DIV-1:
    - gain_cur moves one step toward target;
    - counter clears;
    - if the new gain_cur == target, return to IDLE.
  - gain_load in RAMP updates target without resetting the counter, and the direction re-evaluates.
  - gain_load with gain_code == gain_cur in RAMP goes to IDLE immediately; the counter clears.
  - gain_load with gain_code == gain_cur in IDLE has no effect.
- Simultaneous gain_load and step on the same cycle: the step is taken toward the old target, then target updates. The next step uses the new target.
- Reset mid-ramp or mid-pipeline: everything returns to reset values. No stale out_valid is produced after release.

Optional Feature:
- Macro: AGC_SAT_COUNT_EN.
- Defined:
  - sat_cnt increments by 1 on each output beat with sat=1.
  - It saturates at 16'hFFFF and does not wrap.
  - It clears only on reset.
- Undefined: sat_cnt is driven constant 0 and the counter logic is absent.

Decomposition:
- Shared package agc_pkg holds:
  - constants SAMPLE_W=12, GAIN_W=8, MANT_W=4, EXP_W=4, UNITY_GAIN=8'h80;
  - a gain-code typedef with exp and mant fields.
- One sub-module, agc_gain_mul: a single-channel S2/S3 multiply/shift/round/saturate slice. It is instantiated twice, for I and Q.
- The ramp FSM and the S1 registers live in the top module.

Test Plan:
- Unity: gain 8'h80, sample_i=1234, sample_q=-1234 -> 3 clk later out_i=1234, out_q=-1234, sat=0.
- Rounding: gain 8'h70 (x0.5), sample_i=3 -> out_i=2; sample_i=-3 -> out_i=-1.
- Saturation: gain 8'h90 (x2), sample_i=2047, sample_q=-2048 -> out_i=2047, out_q=-2048, sat=1. With AGC_SAT_COUNT_EN, sat_cnt=1.
- Ramp: RAMP_DIV=8, gain_load with 8'h84 from 8'h80 -> gain_cur steps 81,82,83,84 at 8-clk intervals; ramping falls after 32 clk.
- Retarget: mid-ramp at gain_cur=8'h82 heading to 8'h84, load 8'h80 -> gain_cur steps down to 8'h80, then IDLE.
- Reset mid-ramp with samples in flight: assert rst -> outputs 0, gain_cur=8'h80 asynchronously; no out_valid for 3 clk after release.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared constants and types for the AGC gain-apply stage.
package agc_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned GAIN_W   = 8;
  localparam int unsigned MANT_W   = 4;
  localparam int unsigned EXP_W    = 4;
  localparam int unsigned PROD_W   = SAMPLE_W + MANT_W + 1;
  localparam logic [GAIN_W-1:0] UNITY_GAIN = 8'h80;

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } gain_code_t;

  typedef enum logic {
    RAMP_IDLE = 1'b0,
    RAMP_RUN  = 1'b1
  } ramp_state_t;

endpackage

// File: rtl/agc_gain_mul.sv
// One channel of the gain datapath: S2 multiply register, S3 shift/round/clip logic.
module agc_gain_mul
  import agc_pkg::*;
#(
  parameter int unsigned EXP_BIAS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  gain_code_t                 gain,
  output logic signed [SAMPLE_W-1:0] res_c,
  output logic                       clip_c
);

  localparam int unsigned ACC_W = 34;
  localparam int unsigned SHIFT = EXP_BIAS + 4;
  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (EXP_BIAS + 3);
  localparam logic signed [ACC_W-1:0] MAX_R = (ACC_W'(1) << (SAMPLE_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MIN_R = -(ACC_W'(1) << (SAMPLE_W - 1));

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic [EXP_W-1:0]         exp_q, exp_d;
  logic signed [5:0]        mult;
  logic signed [ACC_W-1:0]  acc, r;

  // S2: sample times (16+m); the exponent travels alongside for S3
  always_comb begin
    mult   = $signed({2'b01, gain.mant});
    prod_d = prod_q;
    exp_d  = exp_q;
    if (en) begin
      prod_d = PROD_W'(sample) * PROD_W'(mult);
      exp_d  = gain.exp;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
      exp_q  <= '0;
    end else begin
      prod_q <= prod_d;
      exp_q  <= exp_d;
    end
  end

  // S3: adding half an LSB before the arithmetic shift rounds ties toward +inf
  always_comb begin
    acc    = (ACC_W'(prod_q) <<< exp_q) + HALF;
    r      = acc >>> SHIFT;
    clip_c = 1'b0;
    res_c  = SAMPLE_W'(r);
    if (r > MAX_R) begin
      res_c  = SAMPLE_W'(MAX_R);
      clip_c = 1'b1;
    end else if (r < MIN_R) begin
      res_c  = SAMPLE_W'(MIN_R);
      clip_c = 1'b1;
    end
  end

endmodule

// File: rtl/agc_gain_apply.sv
// AGC variable-gain stage: ramped gain control plus 3-stage I/Q scaling pipeline.
// Define AGC_SAT_COUNT_EN to build the saturating sat_cnt event counter.
module agc_gain_apply
  import agc_pkg::*;
#(
  parameter logic [GAIN_W-1:0] INIT_GAIN = UNITY_GAIN,
  parameter int unsigned       EXP_BIAS  = 8,
  parameter int unsigned       RAMP_DIV  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic signed [SAMPLE_W-1:0] sample_q,
  input  logic                       gain_load,
  input  logic [GAIN_W-1:0]          gain_code,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] out_i,
  output logic signed [SAMPLE_W-1:0] out_q,
  output logic                       sat,
  output logic [GAIN_W-1:0]          gain_cur,
  output logic                       ramping,
  output logic [15:0]                sat_cnt
);

  localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  ramp_state_t       state_q, state_d;
  logic [GAIN_W-1:0] gain_cur_q, gain_cur_d, target_q, target_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ramping_q, ramping_d, step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RAMP_IDLE;
    else      state_q <= state_d;
  end

  // A step moves toward the target held before any same-cycle load
  always_comb begin
    step       = 1'b0;
    gain_cur_d = gain_cur_q;
    target_d   = target_q;
    cnt_d      = '0;
    if (state_q == RAMP_RUN) begin
      step  = (cnt_q == CNT_LAST);
      cnt_d = step ? '0 : cnt_q + CNT_W'(1);
      if (step) begin
        gain_cur_d = (target_q > gain_cur_q) ? gain_cur_q + GAIN_W'(1)
                                             : gain_cur_q - GAIN_W'(1);
      end
    end
    if (gain_load) target_d = gain_code;
    if (gain_cur_d == target_d) cnt_d = '0;
  end

  always_comb begin
    state_d = RAMP_IDLE;
    if (gain_cur_d != target_d) state_d = RAMP_RUN;
  end

  always_comb begin
    ramping_d = (state_d == RAMP_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gain_cur_q <= INIT_GAIN;
      target_q   <= INIT_GAIN;
      cnt_q      <= '0;
      ramping_q  <= 1'b0;
    end else begin
      gain_cur_q <= gain_cur_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      ramping_q  <= ramping_d;
    end
  end

  logic                       v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
  logic signed [SAMPLE_W-1:0] si_q, si_d, sq_q, sq_d;
  logic signed [SAMPLE_W-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic signed [SAMPLE_W-1:0] res_i_c, res_q_c;
  logic                       clip_i_c, clip_q_c, sat_q, sat_d;
  gain_code_t                 g1_q, g1_d;

  // S1 captures the pair with one gain so a ramp step never splits I from Q
  always_comb begin
    v1_d        = sample_valid;
    si_d        = si_q;
    sq_d        = sq_q;
    g1_d        = g1_q;
    v2_d        = v1_q;
    out_valid_d = v2_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    sat_d       = 1'b0;
    if (sample_valid) begin
      si_d = sample_i;
      sq_d = sample_q;
      g1_d = gain_code_t'(gain_cur_q);
    end
    if (v2_q) begin
      out_i_d = res_i_c;
      out_q_d = res_q_c;
      sat_d   = clip_i_c | clip_q_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q        <= 1'b0;
      si_q        <= '0;
      sq_q        <= '0;
      g1_q        <= '0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      si_q        <= si_d;
      sq_q        <= sq_d;
      g1_q        <= g1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      sat_q       <= sat_d;
    end
  end

  agc_gain_mul #(.EXP_BIAS(EXP_BIAS)) u_mul_i (
    .clk    (clk),
    .rst    (rst),
    .en     (v1_q),
    .sample (si_q),
    .gain   (g1_q),
    .res_c  (res_i_c),
    .clip_c (clip_i_c)
  );

  agc_gain_mul #(.EXP_BIAS(EXP_BIAS)) u_mul_q (
    .clk    (clk),
    .rst    (rst),
    .en     (v1_q),
    .sample (sq_q),
    .gain   (g1_q),
    .res_c  (res_q_c),
    .clip_c (clip_q_c)
  );

`ifdef AGC_SAT_COUNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Counts alongside the sat output and sticks at all-ones
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_d && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sat_cnt_q <= '0;
    else      sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`else
  assign sat_cnt = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign sat       = sat_q;
  assign gain_cur  = gain_cur_q;
  assign ramping   = ramping_q;

endmodule
